// File: rtl/rtc_bus_responder.sv
// RTC stand-in on a multiplexed address/data bus: BCD calendar clock, BCD countdown
// timer with an active-low expiry interrupt, and a synchronised bus-side FSM.
module rtc_bus_responder #(
    parameter int TICK_DIV    = 100000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_d,
    input  logic       cs,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       irq_n,
    output logic       tick
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // Sync word layout: {a_d, cs, rd, wr, ad_in}; strobes idle high so reset makes no edges.
    localparam logic [11:0] SYNC_IDLE = 12'b0111_0000_0000;

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_WDATA, ST_RDRIVE} state_t;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] >= 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
        else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) bcd_dec = {v[7:4] - 4'd1, 4'd9};
        else                bcd_dec = {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [7:0] month_last(input logic [7:0] mon);
        case (mon)
            8'h02:                      month_last = 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: month_last = 8'h30;
            default:                    month_last = 8'h31;
        endcase
    endfunction

    logic [11:0]      r_sync [SYNC_STAGES];
    logic             r_rd_d, r_wr_d;
    state_t           r_state;
    logic [7:0]       r_addr, r_ad_out;
    logic             r_ad_oe;
    logic [DIV_W-1:0] r_div;
    logic             r_tick, r_tick_defer;
    logic [7:0]       r_sec, r_min, r_hour, r_day, r_mon, r_year;
    logic [7:0]       r_tsec, r_tmin, r_thour;
    logic             r_timer_en, r_irq_n;

    logic       w_a_d_s, w_cs_s, w_rd_s, w_wr_s;
    logic [7:0] w_ad_s, w_rd_data;
    logic       w_wr_end, w_rd_start, w_addr_latch, w_commit;
    logic       w_tick_due, w_tick_apply;
    logic       w_sec_c, w_min_c, w_hour_c, w_day_c, w_mon_c;
    logic       w_timer_zero, w_timer_one;

    assign {w_a_d_s, w_cs_s, w_rd_s, w_wr_s, w_ad_s} = r_sync[SYNC_STAGES-1];
    assign w_wr_end     = w_wr_s & ~r_wr_d;
    assign w_rd_start   = ~w_rd_s & r_rd_d;
    assign w_addr_latch = (r_state == ST_ADDR)  & w_wr_end & ~w_cs_s & ~w_a_d_s & w_rd_s;
    assign w_commit     = (r_state == ST_WDATA) & w_wr_end & ~w_cs_s &  w_a_d_s & w_rd_s;

    assign w_tick_due   = (r_div == DIV_W'(TICK_DIV - 1));
    // A commit can never repeat on the next cycle, so a deferred tick never collides again.
    assign w_tick_apply = (w_tick_due & ~w_commit) | r_tick_defer;

    assign w_sec_c  = (r_sec >= 8'h59);
    assign w_min_c  = w_sec_c  & (r_min  >= 8'h59);
    assign w_hour_c = w_min_c  & (r_hour >= 8'h23);
    assign w_day_c  = w_hour_c & (r_day  >= month_last(r_mon));
    assign w_mon_c  = w_day_c  & (r_mon  >= 8'h12);

    assign w_timer_zero = (r_tsec == 8'h00) & (r_tmin == 8'h00) & (r_thour == 8'h00);
    assign w_timer_one  = (r_tsec == 8'h01) & (r_tmin == 8'h00) & (r_thour == 8'h00);

    assign ad_out = r_ad_out;
    assign ad_oe  = r_ad_oe;
    assign irq_n  = r_irq_n;
    assign tick   = r_tick;

    // Bus synchroniser chain plus strobe edge-detect flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= SYNC_IDLE;
            r_rd_d <= 1'b1;
            r_wr_d <= 1'b1;
        end else begin
            r_sync[0] <= {a_d, cs, rd, wr, ad_in};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_rd_d <= w_rd_s;
            r_wr_d <= w_wr_s;
        end
    end

    // Register read multiplexer.
    always_comb begin
        w_rd_data = 8'h00;
        case (r_addr)
            8'h00:   w_rd_data = {~r_irq_n, 6'b000000, r_timer_en};
            8'h21:   w_rd_data = r_sec;
            8'h22:   w_rd_data = r_min;
            8'h23:   w_rd_data = r_hour;
            8'h24:   w_rd_data = r_day;
            8'h25:   w_rd_data = r_mon;
            8'h26:   w_rd_data = r_year;
            8'h41:   w_rd_data = r_tsec;
            8'h42:   w_rd_data = r_tmin;
            8'h43:   w_rd_data = r_thour;
            default: w_rd_data = 8'h00;
        endcase
    end

    // Bus FSM: address latch, read snapshot and output-enable control.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_addr   <= 8'h00;
            r_ad_out <= 8'h00;
            r_ad_oe  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_cs_s && w_a_d_s && w_rd_start) begin
                        r_state  <= ST_RDRIVE;
                        r_ad_out <= w_rd_data;
                        r_ad_oe  <= 1'b1;
                    end else if (!w_cs_s && w_rd_s && !w_wr_s) begin
                        r_state <= w_a_d_s ? ST_WDATA : ST_ADDR;
                    end
                end
                ST_ADDR, ST_WDATA: begin
                    if (w_cs_s) begin
                        r_state <= ST_IDLE;
                    end else if (w_a_d_s && w_rd_start) begin
                        r_state  <= ST_RDRIVE;
                        r_ad_out <= w_rd_data;
                        r_ad_oe  <= 1'b1;
                    end else if (w_wr_end) begin
                        r_state <= ST_IDLE;
                        if (w_addr_latch) r_addr <= w_ad_s;
                    end
                end
                ST_RDRIVE: begin
                    if (w_cs_s || w_rd_s) begin
                        r_state <= ST_IDLE;
                        r_ad_oe <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ad_oe <= 1'b0;
                end
            endcase
        end
    end

    // One-second divider and write-collision deferral.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div        <= '0;
            r_tick       <= 1'b0;
            r_tick_defer <= 1'b0;
        end else begin
            r_div        <= w_tick_due ? '0 : r_div + DIV_W'(1);
            r_tick       <= w_tick_due;
            r_tick_defer <= w_tick_due & w_commit;
        end
    end

    // Register file: bus writes, calendar advance and timer countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sec      <= 8'h00;
            r_min      <= 8'h00;
            r_hour     <= 8'h00;
            r_day      <= 8'h01;
            r_mon      <= 8'h01;
            r_year     <= 8'h00;
            r_tsec     <= 8'h00;
            r_tmin     <= 8'h00;
            r_thour    <= 8'h00;
            r_timer_en <= 1'b0;
            r_irq_n    <= 1'b1;
        end else if (w_commit) begin
            case (r_addr)
                8'h00: begin
                    r_timer_en <= w_ad_s[0];
                    if (w_ad_s[1]) r_irq_n <= 1'b1;
                end
                8'h21:   r_sec   <= w_ad_s;
                8'h22:   r_min   <= w_ad_s;
                8'h23:   r_hour  <= w_ad_s;
                8'h24:   r_day   <= w_ad_s;
                8'h25:   r_mon   <= w_ad_s;
                8'h26:   r_year  <= w_ad_s;
                8'h41:   r_tsec  <= w_ad_s;
                8'h42:   r_tmin  <= w_ad_s;
                8'h43:   r_thour <= w_ad_s;
                default: ;
            endcase
        end else if (w_tick_apply) begin
            r_sec <= w_sec_c ? 8'h00 : bcd_inc(r_sec);
            if (w_sec_c)  r_min  <= w_min_c  ? 8'h00 : bcd_inc(r_min);
            if (w_min_c)  r_hour <= w_hour_c ? 8'h00 : bcd_inc(r_hour);
            if (w_hour_c) r_day  <= w_day_c  ? 8'h01 : bcd_inc(r_day);
            if (w_day_c)  r_mon  <= w_mon_c  ? 8'h01 : bcd_inc(r_mon);
            if (w_mon_c)  r_year <= (r_year >= 8'h99) ? 8'h00 : bcd_inc(r_year);
            if (r_timer_en) begin
                if (!w_timer_zero) begin
                    r_tsec <= (r_tsec == 8'h00) ? 8'h59 : bcd_dec(r_tsec);
                    if (r_tsec == 8'h00) r_tmin <= (r_tmin == 8'h00) ? 8'h59 : bcd_dec(r_tmin);
                    if (r_tsec == 8'h00 && r_tmin == 8'h00) r_thour <= bcd_dec(r_thour);
                end
                if (w_timer_zero || w_timer_one) begin
                    r_irq_n    <= 1'b0;
                    r_timer_en <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder; every bus transaction is placed in a fixed
// slot right after a tick pulse so tick counts between write and read are exact.
module tb_rtc_bus_responder;

    logic       clk = 1'b0;
    logic       reset, a_d, cs, rd, wr;
    logic [7:0] ad_in, ad_out;
    logic       ad_oe, irq_n, tick;

    int vectors    = 0;
    int miscompares = 0;

    rtc_bus_responder #(.TICK_DIV(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
        .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .irq_n(irq_n), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge just after a tick has been applied.
    task automatic sync_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (tick === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            vectors++; miscompares++;
            $display("FAIL sync_tick: no tick pulse within 40 cycles, tick=%b required 1", tick);
        end
    endtask

    task automatic addr_phase(input logic [7:0] a);
        cs = 1'b0; a_d = 1'b0; ad_in = a; wr = 1'b0;
        negs(2); wr = 1'b1;
        negs(3); cs = 1'b1;
    endtask

    task automatic win_write(input logic [7:0] a, input logic [7:0] v, input bit late);
        sync_tick();
        addr_phase(a);
        negs(late ? 6 : 1);
        cs = 1'b0; a_d = 1'b1; ad_in = v; wr = 1'b0;
        negs(2); wr = 1'b1;
        negs(late ? 2 : 3); cs = 1'b1;
    endtask

    task automatic win_read(input logic [7:0] a, input logic [7:0] exp, input string name);
        bit seen = 1'b0;
        sync_tick();
        addr_phase(a);
        negs(1);
        cs = 1'b0; a_d = 1'b1; rd = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            negs(1);
            if (ad_oe === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL %s oe_rise: ad_oe=%b required 1 within 4 cycles", name, ad_oe); end
        vectors++;
        if (ad_out !== exp) begin miscompares++; $display("FAIL %s data: ad_out=%h required %h", name, ad_out, exp); end
        rd = 1'b1;
        negs(3);
        vectors++;
        if (ad_oe !== 1'b0) begin miscompares++; $display("FAIL %s oe_fall: ad_oe=%b required 0", name, ad_oe); end
        vectors++;
        if (ad_out !== exp) begin miscompares++; $display("FAIL %s hold: ad_out=%h required %h", name, ad_out, exp); end
        cs = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cs = 1'b1; rd = 1'b1; wr = 1'b1; a_d = 1'b0; ad_in = 8'h00;
        negs(4); reset = 1'b0;
        negs(1);
        vectors++;
        if (ad_oe !== 1'b0) begin miscompares++; $display("FAIL reset_oe: ad_oe=%b required 0", ad_oe); end
        vectors++;
        if (irq_n !== 1'b1) begin miscompares++; $display("FAIL reset_irq: irq_n=%b required 1", irq_n); end
        vectors++;
        if (ad_out !== 8'h00) begin miscompares++; $display("FAIL reset_out: ad_out=%h required 00", ad_out); end
        vectors++;
        if (tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick: tick=%b required 0", tick); end
        win_read(8'h24, 8'h01, "reset_day");
        win_read(8'h25, 8'h01, "reset_month");
        win_read(8'h00, 8'h00, "reset_ctrl");
    endtask

    task automatic test_day_rollover();
        win_write(8'h23, 8'h23, 1'b0);
        win_write(8'h22, 8'h59, 1'b0);
        win_write(8'h21, 8'h59, 1'b0);
        win_read(8'h21, 8'h00, "roll_sec");
        win_read(8'h22, 8'h00, "roll_min");
        win_read(8'h23, 8'h00, "roll_hour");
        win_read(8'h24, 8'h02, "roll_day");
    endtask

    task automatic test_month_end();
        win_write(8'h24, 8'h28, 1'b0);
        win_write(8'h25, 8'h02, 1'b0);
        win_write(8'h23, 8'h23, 1'b0);
        win_write(8'h22, 8'h59, 1'b0);
        win_write(8'h21, 8'h59, 1'b0);
        win_read(8'h24, 8'h01, "feb_day");
        win_read(8'h25, 8'h03, "feb_month");
    endtask

    task automatic test_year_end();
        win_write(8'h26, 8'h99, 1'b0);
        win_write(8'h25, 8'h12, 1'b0);
        win_write(8'h24, 8'h31, 1'b0);
        win_write(8'h23, 8'h23, 1'b0);
        win_write(8'h22, 8'h59, 1'b0);
        win_write(8'h21, 8'h59, 1'b0);
        win_read(8'h26, 8'h00, "ny_year");
        win_read(8'h25, 8'h01, "ny_month");
        win_read(8'h24, 8'h01, "ny_day");
    endtask

    task automatic test_timer();
        win_write(8'h43, 8'h00, 1'b0);
        win_write(8'h42, 8'h01, 1'b0);
        win_write(8'h41, 8'h00, 1'b0);
        win_write(8'h00, 8'h01, 1'b0);
        win_read(8'h41, 8'h59, "tmr_sec_t1");
        win_read(8'h42, 8'h00, "tmr_min_t2");
        repeat (56) sync_tick();
        win_read(8'h41, 8'h01, "tmr_sec_t59");
        vectors++;
        if (irq_n !== 1'b1) begin miscompares++; $display("FAIL tmr_irq_early: irq_n=%b required 1", irq_n); end
        win_read(8'h00, 8'h80, "tmr_ctrl_exp");
        vectors++;
        if (irq_n !== 1'b0) begin miscompares++; $display("FAIL tmr_irq_set: irq_n=%b required 0", irq_n); end
        win_write(8'h00, 8'h02, 1'b0);
        vectors++;
        if (irq_n !== 1'b1) begin miscompares++; $display("FAIL tmr_irq_clr: irq_n=%b required 1", irq_n); end
        win_read(8'h00, 8'h00, "tmr_ctrl_clr");
    endtask

    task automatic test_tick_collision();
        win_write(8'h21, 8'h30, 1'b1);
        win_read(8'h21, 8'h31, "coll_deferred");
        win_read(8'h21, 8'h32, "coll_next");
    endtask

    task automatic test_unmapped_and_abort();
        win_read(8'h55, 8'h00, "unmapped");
        sync_tick();
        addr_phase(8'h26);
        negs(1);
        cs = 1'b0; a_d = 1'b1; ad_in = 8'h77; wr = 1'b0;
        negs(2); cs = 1'b1;
        negs(2); wr = 1'b1;
        negs(2);
        win_read(8'h26, 8'h00, "abort_year");
    endtask

    task automatic test_reset_mid_read();
        bit seen = 1'b0;
        win_write(8'h22, 8'h45, 1'b0);
        sync_tick();
        addr_phase(8'h24);
        negs(1);
        cs = 1'b0; a_d = 1'b1; rd = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            negs(1);
            if (ad_oe === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL rst_rd_oe: ad_oe=%b required 1", ad_oe); end
        reset = 1'b1; rd = 1'b1; cs = 1'b1;
        negs(1);
        vectors++;
        if (ad_oe !== 1'b0) begin miscompares++; $display("FAIL rst_rd_drop: ad_oe=%b required 0", ad_oe); end
        negs(2); reset = 1'b0;
        win_read(8'h22, 8'h00, "rst_min");
    endtask

    initial begin
        test_reset();
        test_day_rollover();
        test_month_end();
        test_year_end();
        test_timer();
        test_tick_collision();
        test_unmapped_and_abort();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
